// File: rtl/pipe_stage_regs_if.sv
// Decoded instruction record and the pipeline bus between the stage-register bank
// and the surrounding datapath (fetch, decode, execute and memory logic).
typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        regWrite;
    logic        memWrite;
    logic        memRead2;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_used;
} instr_t;

interface pipe_stage_regs_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_ir;
    instr_t          de_instr;
    logic [XLEN-1:0] de_rs1_data;
    logic [XLEN-1:0] de_rs2_data;
    logic [XLEN-1:0] de_imm;
    logic [XLEN-1:0] ex_alu_result;
    logic [XLEN-1:0] ex_store_data;
    logic [XLEN-1:0] mem_dout;

    logic [XLEN-1:0] de_pc;
    logic [XLEN-1:0] de_ir;
    logic            de_valid;
    instr_t          ex_instr;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic            ex_valid;
    instr_t          mem_instr;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_store_data;
    logic            mem_valid;
    instr_t          wb_instr;
    logic [XLEN-1:0] wb_alu_result;
    logic [XLEN-1:0] wb_mem_dout;
    logic            wb_valid;

    // master: the register bank; slave: the datapath feeding and consuming it
    modport master (
        input  if_pc, if_ir, de_instr, de_rs1_data, de_rs2_data, de_imm,
               ex_alu_result, ex_store_data, mem_dout,
        output de_pc, de_ir, de_valid,
               ex_instr, ex_rs1_data, ex_rs2_data, ex_imm, ex_valid,
               mem_instr, mem_alu_result, mem_store_data, mem_valid,
               wb_instr, wb_alu_result, wb_mem_dout, wb_valid
    );

    modport slave (
        output if_pc, if_ir, de_instr, de_rs1_data, de_rs2_data, de_imm,
               ex_alu_result, ex_store_data, mem_dout,
        input  de_pc, de_ir, de_valid,
               ex_instr, ex_rs1_data, ex_rs2_data, ex_imm, ex_valid,
               mem_instr, mem_alu_result, mem_store_data, mem_valid,
               wb_instr, wb_alu_result, wb_mem_dout, wb_valid
    );
endinterface

// File: rtl/pipe_stage_regs.sv
// IF/DE, DE/EX, EX/MEM and MEM/WB registers of the 5-stage core with load-use stall,
// flush and branch-redirect handling, plus retire and stall counters.
module pipe_stage_regs #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LW_STALL,
    input  logic             EX_FLUSH,
    input  logic             br_taken,
    output logic             PC_WE,
    pipe_stage_regs_if.master bus,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [XLEN-1:0] de_pc_reg;
    logic [XLEN-1:0] de_ir_reg;
    logic            de_valid_reg;
    instr_t          ex_instr_reg;
    logic [XLEN-1:0] ex_rs1_data_reg;
    logic [XLEN-1:0] ex_rs2_data_reg;
    logic [XLEN-1:0] ex_imm_reg;
    logic            ex_valid_reg;
    instr_t          mem_instr_reg;
    logic [XLEN-1:0] mem_alu_result_reg;
    logic [XLEN-1:0] mem_store_data_reg;
    logic            mem_valid_reg;
    instr_t          wb_instr_reg;
    logic [XLEN-1:0] wb_alu_result_reg;
    logic [XLEN-1:0] wb_mem_dout_reg;
    logic            wb_valid_reg;

    logic front_flush;
    logic mem_bubble;
    logic [1:0] cnt_inc;

    // Branch operands are not valid during a load-use stall, so the stall wins.
    assign front_flush = br_taken && !LW_STALL;
    assign mem_bubble  = LW_STALL || EX_FLUSH;
    assign PC_WE       = !LW_STALL;

    always_ff @(posedge CLK) begin
        if (RST || front_flush) begin
            de_pc_reg       <= '0;
            de_ir_reg       <= '0;
            de_valid_reg    <= 1'b0;
            ex_instr_reg    <= '0;
            ex_rs1_data_reg <= '0;
            ex_rs2_data_reg <= '0;
            ex_imm_reg      <= '0;
            ex_valid_reg    <= 1'b0;
        end else if (!LW_STALL) begin
            de_pc_reg       <= bus.if_pc;
            de_ir_reg       <= bus.if_ir;
            de_valid_reg    <= 1'b1;
            ex_instr_reg    <= bus.de_instr;
            ex_rs1_data_reg <= bus.de_rs1_data;
            ex_rs2_data_reg <= bus.de_rs2_data;
            ex_imm_reg      <= bus.de_imm;
            ex_valid_reg    <= de_valid_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || mem_bubble) begin
            mem_instr_reg      <= '0;
            mem_alu_result_reg <= '0;
            mem_store_data_reg <= '0;
            mem_valid_reg      <= 1'b0;
        end else begin
            mem_instr_reg      <= ex_instr_reg;
            mem_alu_result_reg <= bus.ex_alu_result;
            mem_store_data_reg <= bus.ex_store_data;
            mem_valid_reg      <= ex_valid_reg;
        end
    end

    // MEM/WB keeps advancing during a stall so the load can be forwarded from WB.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_instr_reg      <= '0;
            wb_alu_result_reg <= '0;
            wb_mem_dout_reg   <= '0;
            wb_valid_reg      <= 1'b0;
        end else begin
            wb_instr_reg      <= mem_instr_reg;
            wb_alu_result_reg <= mem_alu_result_reg;
            wb_mem_dout_reg   <= bus.mem_dout;
            wb_valid_reg      <= mem_valid_reg;
        end
    end

    assign cnt_inc[0] = wb_valid_reg;
    assign cnt_inc[1] = LW_STALL;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign instret_cnt = g_cnt[0].cnt_reg;
    assign stall_cnt   = g_cnt[1].cnt_reg;

    assign bus.de_pc          = de_pc_reg;
    assign bus.de_ir          = de_ir_reg;
    assign bus.de_valid       = de_valid_reg;
    assign bus.ex_instr       = ex_instr_reg;
    assign bus.ex_rs1_data    = ex_rs1_data_reg;
    assign bus.ex_rs2_data    = ex_rs2_data_reg;
    assign bus.ex_imm         = ex_imm_reg;
    assign bus.ex_valid       = ex_valid_reg;
    assign bus.mem_instr      = mem_instr_reg;
    assign bus.mem_alu_result = mem_alu_result_reg;
    assign bus.mem_store_data = mem_store_data_reg;
    assign bus.mem_valid      = mem_valid_reg;
    assign bus.wb_instr       = wb_instr_reg;
    assign bus.wb_alu_result  = wb_alu_result_reg;
    assign bus.wb_mem_dout    = wb_mem_dout_reg;
    assign bus.wb_valid       = wb_valid_reg;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: reset, straight-line flow, branch redirect,
// load-use stall, stall+branch, flush, counter wrap and mid-run reset.
module tb_pipe_stage_regs;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             CLK;
    logic             RST;
    logic             LW_STALL;
    logic             EX_FLUSH;
    logic             br_taken;
    logic             PC_WE;
    logic [CNT_W-1:0] instret_cnt;
    logic [CNT_W-1:0] stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    pipe_stage_regs_if #(.XLEN(XLEN)) bus ();

    pipe_stage_regs #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .LW_STALL    (LW_STALL),
        .EX_FLUSH    (EX_FLUSH),
        .br_taken    (br_taken),
        .PC_WE       (PC_WE),
        .bus         (bus),
        .instret_cnt (instret_cnt),
        .stall_cnt   (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Decoder of the small test program, keyed by PC
    function automatic instr_t dec(input logic [31:0] pc);
        instr_t d;
        d    = '0;
        d.pc = pc;
        case (pc)
            32'h10: begin  // BEQ x1, x2
                d.rs1_addr = 5'd1; d.rs2_addr = 5'd2;
                d.rs1_used = 1'b1; d.rs2_used = 1'b1;
            end
            32'h20: begin  // LW x5, 0(x2)
                d.rd_addr = 5'd5; d.rs1_addr = 5'd2;
                d.regWrite = 1'b1; d.memRead2 = 1'b1; d.rs1_used = 1'b1; d.rd_used = 1'b1;
            end
            32'h24: begin  // ADD x6, x5, x1
                d.rd_addr = 5'd6; d.rs1_addr = 5'd5; d.rs2_addr = 5'd1;
                d.regWrite = 1'b1; d.rs1_used = 1'b1; d.rs2_used = 1'b1; d.rd_used = 1'b1;
            end
            default: begin // ADDI
                d.rd_addr = pc[6:2] + 5'd1; d.rs1_addr = pc[6:2];
                d.regWrite = 1'b1; d.rs1_used = 1'b1; d.rd_used = 1'b1;
            end
        endcase
        return d;
    endfunction

    // Datapath stand-in: data values are tagged with the owning instruction's PC
    always_comb begin
        bus.de_instr      = bus.de_valid ? dec(bus.de_pc) : '0;
        bus.de_rs1_data   = bus.de_valid ? bus.de_pc + 32'h100 : '0;
        bus.de_rs2_data   = bus.de_valid ? bus.de_pc + 32'h200 : '0;
        bus.de_imm        = bus.de_valid ? bus.de_pc + 32'h300 : '0;
        bus.ex_alu_result = bus.ex_valid ? bus.ex_instr.pc + 32'h1000 : '0;
        bus.ex_store_data = bus.ex_valid ? bus.ex_instr.pc + 32'h2000 : '0;
        bus.mem_dout      = bus.mem_valid ? bus.mem_instr.pc + 32'h3000 : '0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic feed(input logic [31:0] pc);
        bus.if_pc = pc;
        bus.if_ir = 32'hA000_0000 | pc;
    endtask

    initial begin
        // Reset with stall/branch/flush asserted, then quiet control
        RST = 1'b1; LW_STALL = 1'b1; EX_FLUSH = 1'b1; br_taken = 1'b1;
        bus.if_pc = $urandom; bus.if_ir = $urandom;
        tick();
        LW_STALL = 1'b0; EX_FLUSH = 1'b0; br_taken = 1'b0;
        bus.if_pc = $urandom; bus.if_ir = $urandom;
        tick();
        chk("rst_de_valid", 64'(bus.de_valid), 64'(0));
        chk("rst_ex_valid", 64'(bus.ex_valid), 64'(0));
        chk("rst_mem_valid", 64'(bus.mem_valid), 64'(0));
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'(0));
        chk("rst_de_pc", 64'(bus.de_pc), 64'(0));
        chk("rst_ex_instr", 64'(bus.ex_instr), 64'(0));
        chk("rst_mem_instr", 64'(bus.mem_instr), 64'(0));
        chk("rst_wb_instr", 64'(bus.wb_instr), 64'(0));
        chk("rst_instret", 64'(instret_cnt), 64'(0));
        chk("rst_stall", 64'(stall_cnt), 64'(0));
        chk("rst_pc_we", 64'(PC_WE), 64'(1));

        // Straight-line flow of ADDIs
        RST = 1'b0;
        feed(32'h00); tick();
        chk("de_pc_0", 64'(bus.de_pc), 64'(0));
        chk("de_ir_0", 64'(bus.de_ir), 64'h0000_0000_A000_0000);
        chk("de_valid_0", 64'(bus.de_valid), 64'(1));
        feed(32'h04); tick();
        chk("ex_instr_0", 64'(bus.ex_instr), 64'(dec(32'h00)));
        chk("ex_rs1_0", 64'(bus.ex_rs1_data), 64'h100);
        feed(32'h08); tick();
        chk("mem_pc_0", 64'(bus.mem_instr.pc), 64'(0));
        chk("mem_alu_0", 64'(bus.mem_alu_result), 64'h1000);
        feed(32'h0C); tick();
        chk("wb_pc_0", 64'(bus.wb_instr.pc), 64'(0));
        chk("wb_valid_0", 64'(bus.wb_valid), 64'(1));
        chk("wb_dout_0", 64'(bus.wb_mem_dout), 64'h3000);
        chk("instret_0", 64'(instret_cnt), 64'(0));
        feed(32'h10); tick();
        chk("wb_pc_4", 64'(bus.wb_instr.pc), 64'h4);
        chk("instret_1", 64'(instret_cnt), 64'(1));
        feed(32'h14); tick();
        chk("ex_pc_beq", 64'(bus.ex_instr.pc), 64'h10);
        chk("wb_pc_8", 64'(bus.wb_instr.pc), 64'h8);

        // Taken branch with BEQ in EX
        br_taken = 1'b1; feed(32'h18); #1;
        chk("br_pc_we", 64'(PC_WE), 64'(1));
        tick();
        chk("br_de_valid", 64'(bus.de_valid), 64'(0));
        chk("br_ex_valid", 64'(bus.ex_valid), 64'(0));
        chk("br_ex_instr", 64'(bus.ex_instr), 64'(0));
        chk("br_mem_pc", 64'(bus.mem_instr.pc), 64'h10);
        chk("br_mem_valid", 64'(bus.mem_valid), 64'(1));
        chk("br_wb_pc", 64'(bus.wb_instr.pc), 64'hC);
        br_taken = 1'b0; feed(32'h20); tick();
        chk("instret_4", 64'(instret_cnt), 64'(4));
        chk("wb_pc_10", 64'(bus.wb_instr.pc), 64'h10);

        // Load-use: LW in MEM, dependent ADD in EX
        feed(32'h24); tick();
        feed(32'h28); tick();
        chk("lu_ex_pc", 64'(bus.ex_instr.pc), 64'h24);
        chk("lu_mem_pc", 64'(bus.mem_instr.pc), 64'h20);
        LW_STALL = 1'b1; feed(32'h2C); #1;
        chk("lu_pc_we", 64'(PC_WE), 64'(0));
        tick();
        chk("lu_de_pc", 64'(bus.de_pc), 64'h28);
        chk("lu_ex_instr", 64'(bus.ex_instr), 64'(dec(32'h24)));
        chk("lu_ex_rs1", 64'(bus.ex_rs1_data), 64'h124);
        chk("lu_mem_valid", 64'(bus.mem_valid), 64'(0));
        chk("lu_wb_rd", 64'(bus.wb_instr.rd_addr), 64'(5));
        chk("lu_wb_dout", 64'(bus.wb_mem_dout), 64'h3020);
        chk("lu_stall_1", 64'(stall_cnt), 64'(1));
        LW_STALL = 1'b0; feed(32'h2C); tick();
        chk("lu_rel_mem_pc", 64'(bus.mem_instr.pc), 64'h24);
        chk("lu_rel_ex_pc", 64'(bus.ex_instr.pc), 64'h28);
        chk("instret_6", 64'(instret_cnt), 64'(6));

        // Stall and branch together: stall only
        LW_STALL = 1'b1; br_taken = 1'b1; feed(32'h30); tick();
        chk("sb_de_valid", 64'(bus.de_valid), 64'(1));
        chk("sb_de_pc", 64'(bus.de_pc), 64'h2C);
        chk("sb_ex_instr", 64'(bus.ex_instr), 64'(dec(32'h28)));
        chk("sb_mem_instr", 64'(bus.mem_instr), 64'(0));
        chk("sb_wb_pc", 64'(bus.wb_instr.pc), 64'h24);
        chk("sb_stall_2", 64'(stall_cnt), 64'(2));

        // Back-to-back stall
        br_taken = 1'b0; tick();
        chk("bb_ex_pc", 64'(bus.ex_instr.pc), 64'h28);
        chk("bb_wb_valid", 64'(bus.wb_valid), 64'(0));
        chk("bb_stall_3", 64'(stall_cnt), 64'(3));
        chk("instret_7", 64'(instret_cnt), 64'(7));

        // EX_FLUSH alone bubbles EX/MEM only
        LW_STALL = 1'b0; EX_FLUSH = 1'b1; feed(32'h30); #1;
        chk("fl_pc_we", 64'(PC_WE), 64'(1));
        tick();
        chk("fl_de_pc", 64'(bus.de_pc), 64'h30);
        chk("fl_ex_pc", 64'(bus.ex_instr.pc), 64'h2C);
        chk("fl_mem_valid", 64'(bus.mem_valid), 64'(0));
        EX_FLUSH = 1'b0;

        // Stream until the 4-bit retire counter wraps
        for (int k = 0; k < 11; k++) begin
            feed(32'h34 + 32'(4 * k)); tick();
            if (k == 9) chk("instret_15", 64'(instret_cnt), 64'(15));
        end
        chk("instret_wrap", 64'(instret_cnt), 64'(0));
        chk("full_wb_pc", 64'(bus.wb_instr.pc), 64'h50);
        chk("full_all_valid",
            64'({bus.de_valid, bus.ex_valid, bus.mem_valid, bus.wb_valid}), 64'hF);
        chk("stream_stall_3", 64'(stall_cnt), 64'(3));

        // Reset mid-operation with stall and branch asserted
        RST = 1'b1; LW_STALL = 1'b1; br_taken = 1'b1; feed(32'h60); tick();
        chk("mrst_valids",
            64'({bus.de_valid, bus.ex_valid, bus.mem_valid, bus.wb_valid}), 64'(0));
        chk("mrst_ex_instr", 64'(bus.ex_instr), 64'(0));
        chk("mrst_wb_instr", 64'(bus.wb_instr), 64'(0));
        chk("mrst_wb_alu", 64'(bus.wb_alu_result), 64'(0));
        chk("mrst_instret", 64'(instret_cnt), 64'(0));
        chk("mrst_stall", 64'(stall_cnt), 64'(0));
        RST = 1'b0; LW_STALL = 1'b0; br_taken = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
